// File: rtl/tt_accum_pkg.sv
// Shared types for the tt_accum block.
//   mode_e : operation select encoding (ADD, SUB, ACC, LOAD)
//   MODE_W : width of the mode select field
package tt_accum_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

endpackage : tt_accum_pkg

// File: rtl/tt_accum_core.sv
// Combinational datapath of the accumulator ALU.
// Computes the next result, carry/borrow and accumulator value for one beat.
// Optional macro TT_ACCUM_SATURATE_EN: clamp ADD/ACC to all-ones on carry and
// SUB to zero on borrow; carry still reports the raw carry/borrow.
// Ports:
//   mode        in  operation select
//   a, b        in  operands (b used by ADD/SUB only)
//   acc         in  accumulator value before the edge
//   next_result out WIDTH-bit result
//   next_carry  out carry (ADD/ACC) or borrow (SUB)
//   next_acc    out accumulator value to store if the beat is accepted
module tt_accum_core
  import tt_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   acc,
  output logic [WIDTH-1:0]   next_result,
  output logic               next_carry,
  output logic [WIDTH-1:0]   next_acc
);

  // One extra bit holds carry-out or borrow.
  logic [WIDTH:0] raw;

  always_comb begin
    raw         = '0;
    next_acc    = acc;
    case (mode)
      MODE_ADD:  raw = {1'b0, a} + {1'b0, b};
      MODE_SUB:  raw = {1'b0, a} - {1'b0, b};
      MODE_ACC:  raw = {1'b0, acc} + {1'b0, a};
      MODE_LOAD: raw = {1'b0, a};
      default:   raw = '0;
    endcase
    next_carry  = raw[WIDTH];
    next_result = raw[WIDTH-1:0];
`ifdef TT_ACCUM_SATURATE_EN
    // Clamp toward the overflowing side; LOAD never sets raw[WIDTH].
    if (raw[WIDTH]) begin
      next_result = (mode == MODE_SUB) ? '0 : '1;
    end
`endif
    // Accumulator follows the (possibly clamped) result for ACC and LOAD.
    if ((mode == MODE_ACC) || (mode == MODE_LOAD)) begin
      next_acc = next_result;
    end
  end

endmodule : tt_accum_core

// File: rtl/tt_accum_alu.sv
// Registered ADD/SUB/ACC/LOAD unit with running accumulator, transaction
// counter and valid/ready handshake on both sides (one-deep output buffer
// that passes through on pop).
// Optional macro TT_ACCUM_SATURATE_EN enables saturating arithmetic in the core.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    operand beat offered
//   in_ready    block can accept a beat this cycle (combinational)
//   a, b, mode  operands and operation select, sampled on accept
//   out_valid   result register holds an unconsumed result
//   out_ready   downstream accepts the result
//   result      registered result
//   carry       registered carry/borrow
//   acc         current accumulator
//   txn_cnt     accepted-beat counter, wraps
module tt_accum_alu
  import tt_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [MODE_W-1:0]  mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic [WIDTH-1:0]   acc,
  output logic [CNT_W-1:0]   txn_cnt
);

  logic               accept;
  logic               pop;
  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic [WIDTH-1:0]   core_acc;

  // Buffer frees up in the same cycle it is popped.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  tt_accum_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mode        (mode_e'(mode)),
    .a           (a),
    .b           (b),
    .acc         (acc),
    .next_result (core_result),
    .next_carry  (core_carry),
    .next_acc    (core_acc)
  );

  // Result buffer, accumulator and counter; accept takes priority over pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      acc       <= '0;
      txn_cnt   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= core_result;
      carry     <= core_carry;
      acc       <= core_acc;
      txn_cnt   <= txn_cnt + CNT_W'(1);
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule : tt_accum_alu

// File: tb/tb_tt_accum_alu.sv
// Directed self-checking bench for tt_accum_alu (WIDTH=8, CNT_W=8).
module tb_tt_accum_alu;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;
`ifdef TT_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] txn_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [WIDTH-1:0] exp_acc;

  tt_accum_alu #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .acc       (acc),
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] m, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    in_valid = 1'b1;
    mode     = m;
    a        = va;
    b        = vb;
  endtask

  initial begin
    // Reset for two cycles with a beat offered.
    rst = 1'b1; out_ready = 1'b1;
    beat(2'd0, 8'd3, 8'd4);
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    exp_cnt = '0; exp_acc = '0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_acc",       32'(acc),       32'd0);
    chk("rst_txn_cnt",   32'(txn_cnt),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // ADD with carry.
    beat(2'd0, 8'd200, 8'd100);
    tick(); exp_cnt++;
    chk("add_valid",  32'(out_valid), 32'd1);
    chk("add_result", 32'(result),    SAT ? 32'd255 : 32'd44);
    chk("add_carry",  32'(carry),     32'd1);
    chk("add_acc",    32'(acc),       32'd0);
    chk("add_cnt",    32'(txn_cnt),   32'(exp_cnt));

    // SUB with borrow, then SUB equal operands.
    beat(2'd1, 8'd5, 8'd9);
    tick(); exp_cnt++;
    chk("sub_result", 32'(result), SAT ? 32'd0 : 32'd252);
    chk("sub_carry",  32'(carry),  32'd1);
    beat(2'd1, 8'd9, 8'd9);
    tick(); exp_cnt++;
    chk("sub_eq_result", 32'(result), 32'd0);
    chk("sub_eq_carry",  32'(carry),  32'd0);

    // LOAD then two chained ACC beats.
    beat(2'd3, 8'd10, 8'd77);
    tick(); exp_cnt++;
    chk("load_result", 32'(result), 32'd10);
    chk("load_carry",  32'(carry),  32'd0);
    chk("load_acc",    32'(acc),    32'd10);
    beat(2'd2, 8'd20, 8'd99);
    tick(); exp_cnt++;
    chk("acc1_result", 32'(result), 32'd30);
    chk("acc1_acc",    32'(acc),    32'd30);
    beat(2'd2, 8'd30, 8'd99);
    tick(); exp_cnt++;
    chk("acc2_result", 32'(result),  32'd60);
    chk("acc2_acc",    32'(acc),     32'd60);
    chk("acc2_cnt",    32'(txn_cnt), 32'(exp_cnt));

    // Pop without accept drops out_valid.
    in_valid = 1'b0;
    tick();
    chk("pop_only_valid", 32'(out_valid), 32'd0);

    // ACC overflow: 60 + 250 = 310.
    beat(2'd2, 8'd250, 8'd0);
    tick(); exp_cnt++;
    exp_acc = SAT ? 8'd255 : 8'd54;
    chk("accov_result", 32'(result), 32'(exp_acc));
    chk("accov_carry",  32'(carry),  32'd1);
    chk("accov_acc",    32'(acc),    32'(exp_acc));
    in_valid = 1'b0;
    tick();

    // Backpressure: 3+4 held while a new beat waits.
    out_ready = 1'b0;
    beat(2'd0, 8'd3, 8'd4);
    tick(); exp_cnt++;
    beat(2'd3, 8'd50, 8'd60);
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", 32'(in_ready),  32'd0);
      chk("stall_result",   32'(result),    32'd7);
      chk("stall_valid",    32'(out_valid), 32'd1);
      tick();
    end
    chk("stall_acc", 32'(acc),     32'(exp_acc));
    chk("stall_cnt", 32'(txn_cnt), 32'(exp_cnt));
    // Switch the waiting beat to ADD 50+60 and release.
    beat(2'd0, 8'd50, 8'd60);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick(); exp_cnt++;
    chk("popacc_valid",  32'(out_valid), 32'd1);
    chk("popacc_result", 32'(result),    32'd110);
    chk("popacc_acc",    32'(acc),       32'(exp_acc));
    beat(2'd0, 8'd1, 8'd2);
    tick(); exp_cnt++;
    chk("nobubble_result", 32'(result),  32'd3);
    chk("nobubble_cnt",    32'(txn_cnt), 32'(exp_cnt));
    in_valid = 1'b0;

    // Counter wrap after 256 accepts from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrap_start", 32'(txn_cnt), 32'd0);
    beat(2'd0, 8'd1, 8'd1);
    for (int i = 0; i < 255; i++) tick();
    chk("wrap_255", 32'(txn_cnt), 32'd255);
    tick();
    chk("wrap_0", 32'(txn_cnt), 32'd0);
    in_valid = 1'b0;
    tick();

    // Reset during a stall discards the held result.
    out_ready = 1'b0;
    beat(2'd0, 8'd3, 8'd4);
    tick();
    chk("rstst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstst_valid",  32'(out_valid), 32'd0);
    chk("rstst_result", 32'(result),    32'd0);
    chk("rstst_carry",  32'(carry),     32'd0);
    chk("rstst_cnt",    32'(txn_cnt),   32'd0);
    chk("rstst_ready",  32'(in_ready),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_tt_accum_alu
